// File: rtl/stuff_mem_responder_pkg.sv
// ============================================================================
// stuff_mem_responder_pkg : shared types and constants for the stuff stream
// Revision : 1.0
// ============================================================================
`default_nettype none

package stuff_mem_responder_pkg;

    localparam int STUFF_ADDR_W   = 4;
    localparam int STUFF_DATA_W   = 16;

    localparam int RSP_FIFO_DEPTH = 3;
    localparam int RSP_PTR_W      = 2;
    localparam int RSP_CNT_W      = 2;
    localparam int ERR_COUNT_W    = 8;

    typedef struct packed {
        logic                    rnw;
        logic [STUFF_ADDR_W-1:0] addr;
        logic [STUFF_DATA_W-1:0] wdata;
    } stuffReqSt;

    typedef struct packed {
        logic [STUFF_ADDR_W-1:0] addr;
        logic [STUFF_DATA_W-1:0] rdata;
        logic                    err;
    } stuffRspSt;

    // Pointer increment that wraps at the non-power-of-two FIFO depth.
    function automatic logic [RSP_PTR_W-1:0] rsp_ptr_inc(input logic [RSP_PTR_W-1:0] p);
        return (p == RSP_PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + RSP_PTR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stuff_rsp_fifo.sv
// ============================================================================
// stuff_rsp_fifo : 3-entry response FIFO with registered head output
// Revision : 1.0
// ============================================================================
`default_nettype none

module stuff_rsp_fifo
    import stuff_mem_responder_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [RSP_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]     mem_q [RSP_FIFO_DEPTH];
    logic [WIDTH-1:0]     mem_d [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RSP_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [RSP_CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]     head_q, head_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = rsp_ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = rsp_ptr_inc(rd_ptr_q);
        end
        count_d = count_q + RSP_CNT_W'(push_i) - RSP_CNT_W'(pop_i);
        // Head is looked up in the post-update storage so a push into an
        // empty (or just-drained) FIFO is visible on the very next cycle.
        head_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stuff_mem_responder.sv
// ============================================================================
// stuff_mem_responder : executes stuff read/write requests on a memory port
// Revision : 1.0
// ============================================================================
`default_nettype none

module stuff_mem_responder
    import stuff_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_vld_i,
    output logic                   req_rdy_o,
    input  logic                   req_rnw_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [DATA_W-1:0]      req_wdata_i,

    output logic                   rsp_vld_o,
    input  logic                   rsp_rdy_i,
    output logic [ADDR_W-1:0]      rsp_addr_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   rsp_err_o,

    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    input  logic                   mem_valid_i,

    output logic [ERR_COUNT_W-1:0] err_count_o
);

    localparam int              RSP_W     = ADDR_W + DATA_W + 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic                   rdy_q, rdy_d;
    logic [RSP_CNT_W-1:0]   reserved_q, reserved_d;
    logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
    logic                   pend_err_q, pend_err_d;

    logic                   accept;
    logic                   in_range;
    logic                   read_acc;
    logic                   pop;
    logic                   push;
    logic [DATA_W-1:0]      push_rdata;
    logic [RSP_W-1:0]       push_data;
    logic [RSP_W-1:0]       head_data;
    logic [RSP_CNT_W-1:0]   fifo_count;

    assign accept   = req_vld_i & rdy_q;
    assign in_range = ({1'b0, req_addr_i} < DEPTH_LIM);
    assign read_acc = accept & req_rnw_i;
    assign pop      = rsp_vld_o & rsp_rdy_i;

    assign mem_enable_o = accept & in_range;
    assign mem_write_o  = accept & in_range & ~req_rnw_i;
    assign mem_addr_o   = req_addr_i;
    assign mem_wdata_o  = req_wdata_i;

    // Out-of-range reads never touched memory, so their data is forced to zero.
    assign push       = pend_vld_q;
    assign push_rdata = (!pend_err_q && mem_valid_i) ? mem_rdata_i : '0;
    assign push_data  = {pend_addr_q, push_rdata, pend_err_q};

    always_comb begin
        pend_vld_d  = read_acc;
        pend_addr_d = req_addr_i;
        pend_err_d  = ~in_range;

        reserved_d = reserved_q;
        case ({read_acc, pop})
            2'b10:   reserved_d = reserved_q + RSP_CNT_W'(1);
            2'b01:   reserved_d = reserved_q - RSP_CNT_W'(1);
            default: reserved_d = reserved_q;
        endcase

        // Ready follows the credit state after this cycle's accept/pop, so a
        // third outstanding read closes the port before a fourth can land.
        rdy_d = (reserved_d < RSP_CNT_W'(RSP_FIFO_DEPTH));

        err_count_d = err_count_q;
        if (accept && !in_range && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            reserved_q  <= '0;
            err_count_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_err_q  <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            reserved_q  <= reserved_d;
            err_count_q <= err_count_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_err_q  <= pend_err_d;
        end
    end

    stuff_rsp_fifo #(
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head_data),
        .count_o (fifo_count)
    );

    assign rsp_vld_o   = (fifo_count != '0);
    assign rsp_addr_o  = head_data[RSP_W-1 -: ADDR_W];
    assign rsp_rdata_o = head_data[DATA_W:1];
    assign rsp_err_o   = head_data[0];
    assign req_rdy_o   = rdy_q;
    assign err_count_o = err_count_q;

endmodule

`default_nettype wire
